pwm_capture: RTL and testbench

Measures an incoming PWM waveform and reports its period, its high time and its duty cycle in integer percent. It is the receive-side counterpart of the `pwm` generator: it closes the loop on generated duty cycles and is the checker for the 10 %-step duty control. It sits on a board input pin or an internal PWM net, and feeds status registers or a monitor.

---
 rtl/pwm_capture_pkg.sv | 14 +
 rtl/pwm_capture_if.sv | 24 ++
 rtl/pwm_pct_div.sv | 56 +++++
 rtl/pwm_capture.sv | 139 +++++++++++++
 tb/tb_pwm_capture.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared constants and FSM state type for the PWM capture block.
package pwm_pkg;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned PCT_W       = 7;
  localparam int unsigned DIV_ITER    = 7;
  localparam int unsigned SYNC_STAGES = 2;
  localparam logic [PCT_W-1:0] PCT_FULL = 7'd100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEAS,
    ST_DIV
  } cap_state_t;
endpackage

// File: rtl/pwm_capture_if.sv
// PWM input and measurement result bundle for pwm_capture.
interface pwm_capture_if
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             i_pwm;
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high;
  logic [PCT_W-1:0] o_duty_pct;
  logic             o_valid;
  logic             o_stuck;
  logic             o_drop;

  modport master (
    input  i_pwm,
    output o_period, o_high, o_duty_pct, o_valid, o_stuck, o_drop
  );

  modport slave (
    output i_pwm,
    input  o_period, o_high, o_duty_pct, o_valid, o_stuck, o_drop
  );
endinterface

// File: rtl/pwm_pct_div.sv
// Sequential restoring divider: floor(high*100/period), one quotient bit per cycle.
module pwm_pct_div
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] high,
  input  logic [CNT_W-1:0] period,
  output logic             busy,
  output logic             done,
  output logic [PCT_W-1:0] quotient
);
  localparam int unsigned RW = CNT_W + PCT_W;
  localparam int unsigned IW = $clog2(DIV_ITER);

  logic [RW-1:0]    rem_q;
  logic [RW-1:0]    dsh_q;
  logic [PCT_W-1:0] q_q;
  logic [IW-1:0]    iter_q;
  logic             busy_q;
  logic             fit;

  // quotient includes the bit decided this cycle, so it is complete while done is high
  always_comb begin
    fit      = (rem_q >= dsh_q);
    quotient = {q_q[PCT_W-2:0], fit};
    done     = busy_q && (iter_q == IW'(DIV_ITER - 1));
  end

  assign busy = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dsh_q  <= '0;
      q_q    <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= RW'(high) * RW'(100);
      dsh_q  <= RW'(period) << (DIV_ITER - 1);
      q_q    <= '0;
      iter_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (fit) rem_q <= rem_q - dsh_q;
      dsh_q  <= dsh_q >> 1;
      q_q    <= quotient;
      iter_q <= iter_q + IW'(1);
      if (done) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/pwm_capture.sv
// Measures period, high time and integer duty percent of an asynchronous PWM input.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic          i_clk,
  input logic          i_rst_n,
  pwm_capture_if.master bus
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   synced;
  logic                   rise;

  cap_state_t state_q, state_d;

  logic [CNT_W-1:0] per_cnt, hi_cnt, lat_period, lat_high;
  logic             cnt_max, div_start, div_busy, div_done, timeout, drop;
  logic [PCT_W-1:0] div_q;

  logic [CNT_W-1:0] period_q, high_q;
  logic [PCT_W-1:0] duty_q;
  logic             valid_q, stuck_q;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign rise    = synced & ~prev_q;
  assign cnt_max = (per_cnt == '1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_pwm};
      prev_q <= synced;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    timeout   = 1'b0;
    drop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise)         state_d = ST_MEAS;
        else if (cnt_max) timeout = 1'b1;
      end
      ST_MEAS: begin
        if (rise) begin
          div_start = 1'b1;
          state_d   = ST_DIV;
        end else if (cnt_max) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        // a period shorter than the divide latency is thrown away
        if (rise) drop = 1'b1;
        if (div_done || !div_busy) state_d = ST_MEAS;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // every edge opens a new window: the edge cycle itself is the first high cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      per_cnt    <= '0;
      hi_cnt     <= '0;
      lat_period <= '0;
      lat_high   <= '0;
    end else begin
      if (rise) begin
        per_cnt <= CNT_W'(1);
        hi_cnt  <= CNT_W'(1);
      end else if (timeout) begin
        per_cnt <= '0;
        hi_cnt  <= '0;
      end else begin
        if (!cnt_max)               per_cnt <= per_cnt + CNT_W'(1);
        if (synced && hi_cnt != '1) hi_cnt  <= hi_cnt + CNT_W'(1);
      end
      if (div_start) begin
        lat_period <= per_cnt;
        lat_high   <= hi_cnt;
      end
    end
  end

  pwm_pct_div #(.CNT_W(CNT_W)) u_div (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .start    (div_start),
    .high     (hi_cnt),
    .period   (per_cnt),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      period_q <= '0;
      high_q   <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (div_done) begin
        period_q <= lat_period;
        high_q   <= lat_high;
        duty_q   <= div_q;
        valid_q  <= 1'b1;
        stuck_q  <= 1'b0;
      end else if (timeout) begin
        stuck_q  <= 1'b1;
        period_q <= '1;
        high_q   <= synced ? '1 : '0;
        duty_q   <= synced ? PCT_FULL : '0;
      end
    end
  end

  assign bus.o_period   = period_q;
  assign bus.o_high     = high_q;
  assign bus.o_duty_pct = duty_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_stuck    = stuck_q;
  assign bus.o_drop     = drop;
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: waveforms scored against an edge-level reference model.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pwm_capture_if #(.CNT_W(CW)) bus();

  pwm_capture #(.CNT_W(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int cyc;
    int per;
    int hi;
    int duty;
  } ev_t;

  int  cyc = 0;
  int  base = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  bit  wave[$];
  ev_t obs_v[$], exp_v[$];
  int  obs_d[$], exp_d[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_valid === 1'b1)
      obs_v.push_back(ev_t'{cyc - base, int'(bus.o_period), int'(bus.o_high), int'(bus.o_duty_pct)});
    if (bus.o_drop === 1'b1)
      obs_d.push_back(cyc - base);
  end

  task automatic do_reset();
    bus.i_pwm = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wave.delete();
  endtask

  task automatic add_period(input int p, input int h, input int n);
    for (int r = 0; r < n; r++)
      for (int i = 0; i < p; i++) wave.push_back(i < h);
  endtask

  task automatic add_level(input bit v, input int n);
    for (int i = 0; i < n; i++) wave.push_back(v);
  endtask

  // wave[k] is driven during cycle k; cycle 0 is the first cycle after reset release
  task automatic drive(input int from, input int to);
    for (int k = from; k < to; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        base = cyc;
        obs_v.delete();
        obs_d.delete();
      end
      bus.i_pwm = wave[k];
    end
  endtask

  function automatic bit syn(input int c, input int s);
    int k;
    k = c - 2;
    return (k >= s && k < wave.size()) ? wave[k] : 1'b0;
  endfunction

  // Reference: a rising edge seen at E (two cycles after the pin) either arms the
  // measurement, is dropped if it falls within 7 cycles after the last measured edge,
  // or ends a window [last, E) whose result appears at E+8. A gap of 256 or more
  // cycles between edges means a timeout happened, which disarms.
  task automatic model(input int s);
    int  last, meas, hi, per;
    bit  armed;
    exp_v.delete();
    exp_d.delete();
    armed = 1'b0;
    last  = -1;
    meas  = -1000;
    for (int e = s + 2; e < wave.size() + 2; e++) begin
      if (syn(e, s) && !syn(e - 1, s)) begin
        if (armed && (e - last) >= 256) armed = 1'b0;
        if (!armed) begin
          armed = 1'b1;
        end else if (e > meas && e <= meas + 7) begin
          exp_d.push_back(e - s);
        end else begin
          hi = 0;
          for (int c = last; c < e; c++) hi += int'(syn(c, s));
          per = e - last;
          exp_v.push_back(ev_t'{e + 8 - s, per, hi, (hi * 100) / per});
          meas = e;
        end
        last = e;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_pwm = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.o_period, bus.o_high, bus.o_duty_pct, bus.o_valid, bus.o_stuck, bus.o_drop} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got per=%0d hi=%0d duty=%0d v=%b s=%b d=%b, required all 0",
               bus.o_period, bus.o_high, bus.o_duty_pct, bus.o_valid, bus.o_stuck, bus.o_drop);
    end
    bus.i_pwm = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.o_period, bus.o_high, bus.o_duty_pct, bus.o_valid, bus.o_stuck, bus.o_drop} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got per=%0d hi=%0d duty=%0d v=%b s=%b d=%b, required all 0",
               bus.o_period, bus.o_high, bus.o_duty_pct, bus.o_valid, bus.o_stuck, bus.o_drop);
    end
  endtask

  task automatic test_fixed_30();
    do_reset();
    add_period(10, 3, 5);
    add_level(1'b0, 16);
    model(0);
    drive(0, wave.size());
    @(negedge clk); #1;
    n_checks++;
    if (obs_v.size() !== 4) begin
      n_fail++;
      $display("FAIL fixed30 valid count: got %0d required 4", obs_v.size());
    end
    for (int i = 0; i < obs_v.size() && i < exp_v.size(); i++) begin
      n_checks++;
      if (obs_v[i] !== exp_v[i]) begin
        n_fail++;
        $display("FAIL fixed30 valid[%0d]: got cyc=%0d per=%0d hi=%0d duty=%0d, required cyc=%0d per=%0d hi=%0d duty=%0d",
                 i, obs_v[i].cyc, obs_v[i].per, obs_v[i].hi, obs_v[i].duty,
                 exp_v[i].cyc, exp_v[i].per, exp_v[i].hi, exp_v[i].duty);
      end
    end
    n_checks++;
    if (obs_d.size() !== 0) begin
      n_fail++;
      $display("FAIL fixed30 drops: got %0d required 0", obs_d.size());
    end
    n_checks++;
    if (bus.o_duty_pct !== 7'd30 || bus.o_period !== 8'd10 || bus.o_high !== 8'd3) begin
      n_fail++;
      $display("FAIL fixed30 hold: got per=%0d hi=%0d duty=%0d required 10/3/30",
               bus.o_period, bus.o_high, bus.o_duty_pct);
    end
  endtask

  task automatic test_duty_steps();
    int steps[7] = '{1, 2, 3, 4, 3, 2, 1};
    do_reset();
    foreach (steps[i]) add_period(10, steps[i], 2);
    add_level(1'b0, 16);
    model(0);
    drive(0, wave.size());
    @(negedge clk); #1;
    n_checks++;
    if (obs_v.size() !== exp_v.size()) begin
      n_fail++;
      $display("FAIL steps valid count: got %0d required %0d", obs_v.size(), exp_v.size());
    end
    for (int i = 0; i < obs_v.size() && i < exp_v.size(); i++) begin
      n_checks++;
      if (obs_v[i] !== exp_v[i]) begin
        n_fail++;
        $display("FAIL steps valid[%0d]: got cyc=%0d per=%0d hi=%0d duty=%0d, required cyc=%0d per=%0d hi=%0d duty=%0d",
                 i, obs_v[i].cyc, obs_v[i].per, obs_v[i].hi, obs_v[i].duty,
                 exp_v[i].cyc, exp_v[i].per, exp_v[i].hi, exp_v[i].duty);
      end
    end
  endtask

  task automatic test_short_period();
    do_reset();
    add_period(7, 1, 5);
    add_level(1'b0, 16);
    model(0);
    drive(0, wave.size());
    @(negedge clk); #1;
    n_checks++;
    if (obs_v.size() !== exp_v.size() || obs_d.size() !== exp_d.size()) begin
      n_fail++;
      $display("FAIL short7 counts: got valid=%0d drop=%0d required valid=%0d drop=%0d",
               obs_v.size(), obs_d.size(), exp_v.size(), exp_d.size());
    end
    for (int i = 0; i < obs_v.size() && i < exp_v.size(); i++) begin
      n_checks++;
      if (obs_v[i] !== exp_v[i]) begin
        n_fail++;
        $display("FAIL short7 valid[%0d]: got cyc=%0d per=%0d hi=%0d duty=%0d, required cyc=%0d per=%0d hi=%0d duty=%0d",
                 i, obs_v[i].cyc, obs_v[i].per, obs_v[i].hi, obs_v[i].duty,
                 exp_v[i].cyc, exp_v[i].per, exp_v[i].hi, exp_v[i].duty);
      end
    end
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
      n_checks++;
      if (obs_d[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL short7 drop[%0d]: got cycle %0d required %0d", i, obs_d[i], exp_d[i]);
      end
    end
    n_checks++;
    if (obs_v.size() == 0 || obs_v[0].duty !== 14) begin
      n_fail++;
      $display("FAIL short7 first duty: got %0d required 14", (obs_v.size() != 0) ? obs_v[0].duty : -1);
    end
  endtask

  task automatic test_stuck();
    int resume;
    do_reset();
    add_period(20, 5, 2);
    add_level(1'b1, 300);
    resume = wave.size();
    add_level(1'b0, 15);
    add_period(20, 5, 3);
    add_level(1'b0, 16);
    model(0);
    drive(0, resume);
    @(negedge clk); #1;
    n_checks++;
    if (bus.o_stuck !== 1'b1 || bus.o_duty_pct !== 7'd100 || bus.o_period !== 8'hFF || bus.o_high !== 8'hFF) begin
      n_fail++;
      $display("FAIL stuck levels: got stuck=%b duty=%0d per=%0d hi=%0d required 1/100/255/255",
               bus.o_stuck, bus.o_duty_pct, bus.o_period, bus.o_high);
    end
    n_checks++;
    if (obs_v.size() !== 2) begin
      n_fail++;
      $display("FAIL stuck no valid during hold: got %0d pulses required 2", obs_v.size());
    end
    drive(resume, wave.size());
    @(negedge clk); #1;
    n_checks++;
    if (obs_v.size() !== exp_v.size()) begin
      n_fail++;
      $display("FAIL stuck valid count: got %0d required %0d", obs_v.size(), exp_v.size());
    end
    for (int i = 0; i < obs_v.size() && i < exp_v.size(); i++) begin
      n_checks++;
      if (obs_v[i] !== exp_v[i]) begin
        n_fail++;
        $display("FAIL stuck valid[%0d]: got cyc=%0d per=%0d hi=%0d duty=%0d, required cyc=%0d per=%0d hi=%0d duty=%0d",
                 i, obs_v[i].cyc, obs_v[i].per, obs_v[i].hi, obs_v[i].duty,
                 exp_v[i].cyc, exp_v[i].per, exp_v[i].hi, exp_v[i].duty);
      end
    end
    n_checks++;
    if (bus.o_stuck !== 1'b0 || bus.o_duty_pct !== 7'd25) begin
      n_fail++;
      $display("FAIL stuck recover: got stuck=%b duty=%0d required 0/25", bus.o_stuck, bus.o_duty_pct);
    end
  endtask

  task automatic test_reset_mid_div();
    localparam int R = 35;
    int   pre_duty;
    ev_t  kept[$];
    do_reset();
    add_period(10, 3, 10);
    add_level(1'b0, 16);
    model(0);
    pre_duty = 0;
    foreach (exp_v[i]) if (exp_v[i].cyc <= R) pre_duty = exp_v[i].duty;
    model(R);
    fork
      drive(0, wave.size());
      begin
        repeat (R + 1) @(posedge clk);
        #2;
        n_checks++;
        if (int'(bus.o_duty_pct) !== pre_duty) begin
          n_fail++;
          $display("FAIL rstdiv pre duty: got %0d required %0d", bus.o_duty_pct, pre_duty);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_period, bus.o_high, bus.o_duty_pct, bus.o_valid, bus.o_stuck, bus.o_drop} !== '0) begin
          n_fail++;
          $display("FAIL rstdiv async clear: got per=%0d hi=%0d duty=%0d v=%b s=%b d=%b, required all 0",
                   bus.o_period, bus.o_high, bus.o_duty_pct, bus.o_valid, bus.o_stuck, bus.o_drop);
        end
        rst_n = 1'b1;
      end
    join
    @(negedge clk); #1;
    foreach (obs_v[i]) if (obs_v[i].cyc >= R)
      kept.push_back(ev_t'{obs_v[i].cyc - R, obs_v[i].per, obs_v[i].hi, obs_v[i].duty});
    n_checks++;
    if (kept.size() !== exp_v.size()) begin
      n_fail++;
      $display("FAIL rstdiv valid count: got %0d required %0d", kept.size(), exp_v.size());
    end
    for (int i = 0; i < kept.size() && i < exp_v.size(); i++) begin
      n_checks++;
      if (kept[i] !== exp_v[i]) begin
        n_fail++;
        $display("FAIL rstdiv valid[%0d]: got cyc=%0d per=%0d hi=%0d duty=%0d, required cyc=%0d per=%0d hi=%0d duty=%0d",
                 i, kept[i].cyc, kept[i].per, kept[i].hi, kept[i].duty,
                 exp_v[i].cyc, exp_v[i].per, exp_v[i].hi, exp_v[i].duty);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    add_period(2, 1, 30);
    add_level(1'b0, 16);
    model(0);
    drive(0, wave.size());
    @(negedge clk); #1;
    n_checks++;
    if (obs_d.size() !== exp_d.size() || obs_d.size() < 10) begin
      n_fail++;
      $display("FAIL b2b drop count: got %0d required %0d", obs_d.size(), exp_d.size());
    end
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
      n_checks++;
      if (obs_d[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL b2b drop[%0d]: got cycle %0d required %0d", i, obs_d[i], exp_d[i]);
      end
    end
    n_checks++;
    if (obs_v.size() !== exp_v.size()) begin
      n_fail++;
      $display("FAIL b2b valid count: got %0d required %0d", obs_v.size(), exp_v.size());
    end
    for (int i = 0; i < obs_v.size() && i < exp_v.size(); i++) begin
      n_checks++;
      if (obs_v[i] !== exp_v[i] || obs_v[i].duty !== 50) begin
        n_fail++;
        $display("FAIL b2b valid[%0d]: got cyc=%0d duty=%0d, required cyc=%0d duty=%0d",
                 i, obs_v[i].cyc, obs_v[i].duty, exp_v[i].cyc, exp_v[i].duty);
      end
    end
  endtask

  task automatic test_random();
    int p, h;
    do_reset();
    for (int s = 0; s < 6; s++) begin
      p = int'($urandom_range(40, 3));
      h = int'($urandom_range(p - 1, 1));
      add_period(p, h, int'($urandom_range(4, 2)));
    end
    add_level(1'b0, 16);
    model(0);
    drive(0, wave.size());
    @(negedge clk); #1;
    n_checks++;
    if (obs_v.size() !== exp_v.size() || obs_d.size() !== exp_d.size()) begin
      n_fail++;
      $display("FAIL random counts: got valid=%0d drop=%0d required valid=%0d drop=%0d",
               obs_v.size(), obs_d.size(), exp_v.size(), exp_d.size());
    end
    for (int i = 0; i < obs_v.size() && i < exp_v.size(); i++) begin
      n_checks++;
      if (obs_v[i] !== exp_v[i]) begin
        n_fail++;
        $display("FAIL random valid[%0d]: got cyc=%0d per=%0d hi=%0d duty=%0d, required cyc=%0d per=%0d hi=%0d duty=%0d",
                 i, obs_v[i].cyc, obs_v[i].per, obs_v[i].hi, obs_v[i].duty,
                 exp_v[i].cyc, exp_v[i].per, exp_v[i].hi, exp_v[i].duty);
      end
    end
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
      n_checks++;
      if (obs_d[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL random drop[%0d]: got cycle %0d required %0d", i, obs_d[i], exp_d[i]);
      end
    end
  endtask

  initial begin
    bus.i_pwm = 1'b0;
    test_reset();
    test_fixed_30();
    test_duty_steps();
    test_short_period();
    test_stuck();
    test_reset_mid_div();
    test_back_to_back();
    for (int r = 0; r < 4; r++) test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1);
  end
endmodule
